// File: rtl/alu_seq.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : alu_seq
// Purpose  : Multi-cycle ALU with busy/done handshake; serial shifts and
//            shift-add multiply, registered result and C/Z/V/N flags.
// Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             oe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aluout,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_WIDTH_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_ONE_CNT   = CNT_W'(1);

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_ADC = 4'd1;
    localparam logic [3:0] c_OP_SUB = 4'd2;
    localparam logic [3:0] c_OP_SBC = 4'd3;
    localparam logic [3:0] c_OP_AND = 4'd4;
    localparam logic [3:0] c_OP_OR  = 4'd5;
    localparam logic [3:0] c_OP_XOR = 4'd6;
    localparam logic [3:0] c_OP_NOT = 4'd7;
    localparam logic [3:0] c_OP_SHL = 4'd8;
    localparam logic [3:0] c_OP_SHR = 4'd9;
    localparam logic [3:0] c_OP_ASR = 4'd10;
    localparam logic [3:0] c_OP_MUL = 4'd11;
    localparam logic [3:0] c_OP_CMP = 4'd12;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_op, w_op_nxt;
    logic [WIDTH-1:0]       r_acc, w_acc_nxt;
    logic [2*WIDTH-1:0]     r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0]       r_mplier, w_mplier_nxt;
    logic [2*WIDTH-1:0]     r_prod, w_prod_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]       r_result, w_result_nxt;
    logic                   r_fc, r_fz, r_fv, r_fn;
    logic                   w_fc_nxt, w_fz_nxt, w_fv_nxt, w_fn_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;

    logic                   w_is_run;
    logic [CNT_W-1:0]       w_shamt_raw;
    logic [CNT_W-1:0]       w_shamt;
    logic [WIDTH-1:0]       w_bb;
    logic                   w_cin;
    logic [WIDTH:0]         w_sum;
    logic                   w_add_v;
    logic [WIDTH-1:0]       w_logic;
    logic [3:0]             w_op_cur;
    logic [WIDTH-1:0]       w_sh_src;
    logic [WIDTH-1:0]       w_sh_val;
    logic                   w_sh_out;
    logic [2*WIDTH-1:0]     w_mc_src;
    logic [WIDTH-1:0]       w_mp_src;
    logic [2*WIDTH-1:0]     w_pr_src;
    logic [2*WIDTH-1:0]     w_pr_step;

    assign w_is_run    = (r_state == S_RUN);
    assign w_shamt_raw = b[CNT_W-1:0];
    assign w_shamt     = (w_shamt_raw > c_WIDTH_CNT) ? c_WIDTH_CNT : w_shamt_raw;

    // Subtraction is a + ~b + cin so C reads as "no borrow".
    always_comb begin
        w_bb  = b;
        w_cin = 1'b0;
        case (op)
            c_OP_ADC: w_cin = carryin;
            c_OP_SUB,
            c_OP_CMP: begin
                w_bb  = ~b;
                w_cin = 1'b1;
            end
            c_OP_SBC: begin
                w_bb  = ~b;
                w_cin = carryin;
            end
            default: ;
        endcase
    end

    assign w_sum   = {1'b0, a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, w_cin};
    assign w_add_v = (a[WIDTH-1] == w_bb[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        case (op)
            c_OP_AND: w_logic = a & b;
            c_OP_OR:  w_logic = a | b;
            c_OP_XOR: w_logic = a ^ b;
            default:  w_logic = ~a;
        endcase
    end

    // One shift / multiply step, fed from the ports at issue and from the
    // working registers while running, so both phases share one datapath.
    assign w_op_cur = w_is_run ? r_op : op;
    assign w_sh_src = w_is_run ? r_acc : a;

    always_comb begin
        case (w_op_cur)
            c_OP_SHL: begin
                w_sh_val = {w_sh_src[WIDTH-2:0], 1'b0};
                w_sh_out = w_sh_src[WIDTH-1];
            end
            c_OP_SHR: begin
                w_sh_val = {1'b0, w_sh_src[WIDTH-1:1]};
                w_sh_out = w_sh_src[0];
            end
            default: begin
                w_sh_val = {w_sh_src[WIDTH-1], w_sh_src[WIDTH-1:1]};
                w_sh_out = w_sh_src[0];
            end
        endcase
    end

    assign w_mc_src  = w_is_run ? r_mcand  : {{WIDTH{1'b0}}, a};
    assign w_mp_src  = w_is_run ? r_mplier : b;
    assign w_pr_src  = w_is_run ? r_prod   : '0;
    assign w_pr_step = w_pr_src + (w_mp_src[0] ? w_mc_src : '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_prod_nxt   = r_prod;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_fc_nxt     = r_fc;
        w_fz_nxt     = r_fz;
        w_fv_nxt     = r_fv;
        w_fn_nxt     = r_fn;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_op_nxt = op;
                    case (op)
                        c_OP_ADD, c_OP_ADC, c_OP_SUB, c_OP_SBC, c_OP_CMP: begin
                            if (op != c_OP_CMP) begin
                                w_result_nxt = w_sum[WIDTH-1:0];
                            end
                            w_fc_nxt   = w_sum[WIDTH];
                            w_fz_nxt   = (w_sum[WIDTH-1:0] == '0);
                            w_fv_nxt   = w_add_v;
                            w_fn_nxt   = w_sum[WIDTH-1];
                            w_done_nxt = 1'b1;
                        end
                        c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_NOT: begin
                            w_result_nxt = w_logic;
                            w_fz_nxt     = (w_logic == '0);
                            w_fv_nxt     = 1'b0;
                            w_fn_nxt     = w_logic[WIDTH-1];
                            w_done_nxt   = 1'b1;
                        end
                        c_OP_SHL, c_OP_SHR, c_OP_ASR: begin
                            if (w_shamt == '0) begin
                                w_result_nxt = a;
                                w_fz_nxt     = (a == '0);
                                w_fv_nxt     = 1'b0;
                                w_fn_nxt     = a[WIDTH-1];
                                w_done_nxt   = 1'b1;
                            end else if (w_shamt == c_ONE_CNT) begin
                                w_result_nxt = w_sh_val;
                                w_fc_nxt     = w_sh_out;
                                w_fz_nxt     = (w_sh_val == '0);
                                w_fv_nxt     = 1'b0;
                                w_fn_nxt     = w_sh_val[WIDTH-1];
                                w_done_nxt   = 1'b1;
                            end else begin
                                w_acc_nxt   = w_sh_val;
                                w_cnt_nxt   = w_shamt - c_ONE_CNT;
                                w_busy_nxt  = 1'b1;
                                w_state_nxt = S_RUN;
                            end
                        end
                        c_OP_MUL: begin
                            w_prod_nxt   = w_pr_step;
                            w_mcand_nxt  = w_mc_src << 1;
                            w_mplier_nxt = w_mp_src >> 1;
                            w_cnt_nxt    = c_WIDTH_CNT - c_ONE_CNT;
                            w_busy_nxt   = 1'b1;
                            w_state_nxt  = S_RUN;
                        end
                        default: w_done_nxt = 1'b1;
                    endcase
                end
            end

            S_RUN: begin
                if (r_op == c_OP_MUL) begin
                    w_prod_nxt   = w_pr_step;
                    w_mcand_nxt  = w_mc_src << 1;
                    w_mplier_nxt = w_mp_src >> 1;
                end else begin
                    w_acc_nxt = w_sh_val;
                end

                if (r_cnt == c_ONE_CNT) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_fv_nxt    = 1'b0;
                    if (r_op == c_OP_MUL) begin
                        w_result_nxt = w_pr_step[WIDTH-1:0];
                        w_fc_nxt     = |w_pr_step[2*WIDTH-1:WIDTH];
                        w_fz_nxt     = (w_pr_step[WIDTH-1:0] == '0);
                        w_fn_nxt     = w_pr_step[WIDTH-1];
                    end else begin
                        w_result_nxt = w_sh_val;
                        w_fc_nxt     = w_sh_out;
                        w_fz_nxt     = (w_sh_val == '0);
                        w_fn_nxt     = w_sh_val[WIDTH-1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE_CNT;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_fc     <= 1'b0;
            r_fz     <= 1'b0;
            r_fv     <= 1'b0;
            r_fn     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_prod   <= w_prod_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_fc     <= w_fc_nxt;
            r_fz     <= w_fz_nxt;
            r_fv     <= w_fv_nxt;
            r_fn     <= w_fn_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign aluout = oe ? r_result : '0;
    assign flag_c = r_fc;
    assign flag_z = r_fz;
    assign flag_v = r_fv;
    assign flag_n = r_fn;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Directed scoreboard bench for alu_seq at WIDTH=8.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 8;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_ASR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12;
    localparam logic [3:0] OP_RSV = 4'd13;

    logic         clk = 1'b0;
    logic         rst_n, start, carryin, oe;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] aluout;
    logic         flag_c, flag_z, flag_v, flag_n;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .carryin (carryin),
        .oe      (oe),
        .busy    (busy),
        .done    (done),
        .aluout  (aluout),
        .flag_c  (flag_c),
        .flag_z  (flag_z),
        .flag_v  (flag_v),
        .flag_n  (flag_n)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         c, z, v, n;
        int           cyc;
        string        nm;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected done", 32'd1, 32'd0);
            end else begin
                m_e = q.pop_front();
                check({m_e.nm, " result/flags"},
                      {20'd0, aluout, flag_c, flag_z, flag_v, flag_n},
                      {20'd0, m_e.res, m_e.c, m_e.z, m_e.v, m_e.n});
                check({m_e.nm, " latency"}, cyc, m_e.cyc);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // f = {C, Z, V, N}
    task automatic issue(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic ci, input bit push, input logic [W-1:0] r,
                         input logic [3:0] f, input int lat, input string nm);
        exp_t e;
        start   = 1'b1;
        op      = o;
        a       = aa;
        b       = bb;
        carryin = ci;
        if (push) begin
            e.res = r;
            e.c   = f[3];
            e.z   = f[2];
            e.v   = f[1];
            e.n   = f[0];
            e.cyc = cyc + lat;
            e.nm  = nm;
            q.push_back(e);
        end
        sync();
        start   = 1'b0;
        op      = 4'($urandom);
        a       = W'($urandom);
        b       = W'($urandom);
        carryin = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input string nm, output int nb);
        bit seen;
        seen = 1'b0;
        nb   = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) check({nm, " done timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ci, input logic [W-1:0] r, input logic [3:0] f,
                       input int lat, input string nm);
        int nb;
        sync();
        issue(o, aa, bb, ci, 1'b1, r, f, lat, nm);
        wait_done(nm, nb);
        check({nm, " busy cycles"}, nb, lat - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        int nd;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = '0;
        a       = '0;
        b       = '0;
        carryin = 1'b0;
        oe      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset state", {18'd0, aluout, busy, done, flag_c, flag_z, flag_v, flag_n}, 32'd0);

        run(OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011, 1, "add_ovf");
        #2;
        oe = 1'b0;
        #1;
        check("oe low gates aluout", {24'd0, aluout}, 32'd0);
        oe = 1'b1;
        #1;
        check("oe high shows result", {24'd0, aluout}, 32'h80);

        run(OP_SUB, 8'h10, 8'h20, 1'b0, 8'hF0, 4'b0001, 1, "sub_borrow");
        run(OP_CMP, 8'h05, 8'h05, 1'b0, 8'hF0, 4'b1100, 1, "cmp_eq");
        run(OP_SHL, 8'h81, 8'h01, 1'b0, 8'h02, 4'b1000, 1, "shl1");
        run(OP_ASR, 8'h80, 8'h09, 1'b0, 8'hFF, 4'b1001, 8, "asr_sat");
        run(OP_SHR, 8'h54, 8'h00, 1'b0, 8'h54, 4'b1000, 1, "shr0");
        run(OP_SHR, 8'h50, 8'h03, 1'b0, 8'h0A, 4'b0000, 3, "shr3");
        run(OP_MUL, 8'h13, 8'h0D, 1'b0, 8'hF7, 4'b0001, 8, "mul");
        run(OP_MUL, 8'h20, 8'h10, 1'b0, 8'h00, 4'b1100, 8, "mul_ovf");
        run(OP_XOR, 8'hF0, 8'hFF, 1'b0, 8'h0F, 4'b1000, 1, "xor");
        run(OP_AND, 8'hAA, 8'h55, 1'b0, 8'h00, 4'b1100, 1, "and");
        run(OP_ADC, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b0011, 1, "adc");
        run(OP_SBC, 8'h00, 8'h01, 1'b0, 8'hFE, 4'b0001, 1, "sbc");
        run(OP_NOT, 8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0001, 1, "not");
        run(OP_RSV, 8'hFF, 8'hFF, 1'b1, 8'hF0, 4'b0001, 1, "reserved");
        run(OP_OR,  8'h00, 8'h00, 1'b0, 8'h00, 4'b0100, 1, "or_zero");
        run(OP_SHL, 8'h01, 8'h0F, 1'b0, 8'h00, 4'b1100, 8, "shl_sat");

        // Start pulsed mid-MUL is dropped; start in the done cycle is taken.
        sync();
        issue(OP_MUL, 8'h0F, 8'h0F, 1'b0, 1'b1, 8'hE1, 4'b0001, 8, "mul_ignore");
        sync();
        sync();
        start   = 1'b1;
        op      = OP_ADD;
        a       = 8'h01;
        b       = 8'h01;
        carryin = 1'b0;
        sync();
        start = 1'b0;
        repeat (4) sync();
        check("done in b2b cycle", {31'd0, done}, 32'd1);
        issue(OP_ADD, 8'h01, 8'h02, 1'b0, 1'b1, 8'h03, 4'b0000, 1, "b2b_add");
        wait_done("b2b_add", nb);
        check("b2b_add busy cycles", nb, 0);

        run(OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b1010, 1, "sub_v");

        // Asynchronous reset in cycle 4 of a MUL.
        sync();
        issue(OP_MUL, 8'h13, 8'h0D, 1'b0, 1'b0, 8'h00, 4'b0000, 8, "mul_abort");
        repeat (3) sync();
        check("busy before abort", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort clears outputs",
              {18'd0, aluout, busy, done, flag_c, flag_z, flag_v, flag_n}, 32'd0);
        repeat (2) sync();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("no done after abort", nd, 0);
        check("idle after abort", {31'd0, busy}, 32'd0);

        check("scoreboard drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle CPU ALU.
- Executes one operation per start request on `WIDTH`-bit operands and reports completion with a busy/done handshake.
- Holds the result and the C/Z/V/N flags in registers until the next completion.
- Shifts run one bit per cycle and multiply is iterative shift-add, so the control FSM in the CPU core must wait on `done`.

Parameters:
- WIDTH, 8, datapath width in bits; legal values 4..32. Counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  4  operation code, captured with start.
- a  input  WIDTH  operand A, captured with start.
- b  input  WIDTH  operand B or shift amount, captured with start.
- carryin  input  1  carry input for ADC/SBC, captured with start.
- oe  input  1  output enable for aluout; combinational gate.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle completion pulse.
- aluout  output  WIDTH  oe ? result_q : 0.
- flag_c, flag_z, flag_v, flag_n  output  1 each  registered flags.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; busy, done, result_q and all flags cleared to 0; the iteration counter is cleared. Reset mid-operation aborts the operation with no partial result.
- FSM:
  - IDLE: start=1 captures op/a/b/carryin.
  - Single-cycle op: result and flags are written at the same edge; done=1 next cycle; state stays IDLE.
  - Multi-cycle op: go to RUN.
  - RUN: busy=1; one iteration per cycle. On the final iteration, write result and flags, pulse done, return to IDLE.
- Latency L (from the start-sampling edge to done high): 1 for single-cycle ops; max(1, min(shamt, WIDTH)) for shifts; WIDTH for MUL.
- busy is high during cycles 1..L-1. done is high for exactly cycle L.
- A start asserted while busy=1 is ignored and not queued. A start in the done cycle is accepted (back-to-back).
- Opcodes (sum is a WIDTH+1-bit add):
  - 0 ADD: a+b.
  - 1 ADC: a+b+carryin.
  - 2 SUB: a+~b+1.
  - 3 SBC: a+~b+carryin.
  - 4 AND, 5 OR, 6 XOR.
  - 7 NOT: ~a.
  - 8 SHL, 9 SHR (logical), 10 ASR.
  - 11 MUL: low WIDTH bits of a*b.
  - 12 CMP: SUB with flags updated and result_q unchanged.
  - 13–15 reserved: single-cycle, result_q and flags unchanged, done still pulses.
- Flags, add/sub class (0–3, 12):
  - C = sum[WIDTH]. A borrow on SUB gives C=0.
  - V = signed overflow of the effective operands (A and effective B same sign, result sign differs).
  - N = MSB of the result. Z = (result == 0).
- Flags, logic ops (4–7): C unchanged, V=0, N and Z from the result.
- Shifts:
  - shamt = b[clog2(WIDTH):0], saturated at WIDTH.
  - shamt ≥ WIDTH yields 0 for SHL/SHR and all-sign for ASR.
  - C = the last bit shifted out; C is unchanged when shamt=0. V=0.
- MUL: C = 1 if the true product exceeds WIDTH bits, else 0. V=0. N and Z from the low WIDTH bits.
- Results and flags change only at the completion edge. Outputs are stable between completions.
- Operand inputs may change freely after capture.

Test Plan (WIDTH=8):
- ADD a=0x7F b=0x01 -> done 1 cycle after start; aluout=0x80 with oe=1, 0x00 with oe=0; C=0 V=1 N=1 Z=0.
- SUB a=0x10 b=0x20 -> 0xF0, C=0 V=0 N=1. Then CMP a=0x05 b=0x05 -> result_q stays 0xF0, Z=1 C=1.
- Shifts:
  - SHL a=0x81 b=1 -> 1-cycle latency, 0x02, C=1.
  - ASR a=0x80 b=9 -> busy for 7 cycles, done on cycle 8, 0xFF, C=1.
  - SHR b=0 -> latency 1, result=a, C unchanged.
- MUL 0x13*0x0D -> done on cycle 8, 0xF7, C=0. MUL 0x20*0x10 -> 0x00, Z=1, C=1.
- During MUL, pulse start with ADD -> ignored, MUL result correct. A start in the done cycle is accepted, and its done follows one cycle later.
- Assert rst_n=0 mid-MUL (cycle 4) -> busy, done, aluout and flags immediately 0. After release, no done occurs until a new start.
